// File: rtl/nd_2to1.sv
// Two-input merge node: two 4-phase receive channels feed one send channel through
// one-entry holding buffers, with round-robin arbitration when both buffers are full.
`timescale 1ns/1ps

`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif

module nd_2to1 #(
    parameter int ASZ = `NS_ADDRESS_SIZE,
    parameter int DSZ = `NS_DATA_SIZE,
    parameter int RSZ = `NS_REDUN_SIZE,
    localparam int MSZ = ASZ + DSZ + RSZ
) (
    input  logic           i_clk,
    input  logic           reset,
    output logic           ready,
    input  logic           rcv0_req,
    input  logic [MSZ-1:0] rcv0_dat,
    output logic           rcv0_ack,
    input  logic           rcv1_req,
    input  logic [MSZ-1:0] rcv1_dat,
    output logic           rcv1_ack,
    output logic           snd0_req,
    output logic [MSZ-1:0] snd0_dat,
    input  logic           snd0_ack
);

    typedef enum logic {RxIdle, RxWaitLo} rx_st_e;
    typedef enum logic [1:0] {TxIdle, TxWaitHi, TxWaitLo} tx_st_e;

    logic                r_ready;
    logic [1:0]          r_sreq_m, r_sreq;
    logic                r_sack_m, r_sack;
    rx_st_e              r_rx_st [2];
    rx_st_e              w_rx_st_nx [2];
    logic [1:0]          r_full, w_full_nx;
    logic [1:0][MSZ-1:0] r_buf, w_buf_nx;
    logic [1:0][MSZ-1:0] w_rcv_dat;
    tx_st_e              r_tx_st, w_tx_st_nx;
    logic                r_sel, w_sel_nx;
    logic                r_ptr, w_ptr_nx;
    logic [MSZ-1:0]      r_snd_dat, w_snd_dat_nx;

    assign w_rcv_dat = {rcv1_dat, rcv0_dat};

    // Peers run on unrelated clocks: two-flop synchronisers on every incoming handshake line.
    always_ff @(posedge i_clk) begin
        if (reset) begin
            r_ready  <= 1'b0;
            r_sreq_m <= '0;
            r_sreq   <= '0;
            r_sack_m <= 1'b0;
            r_sack   <= 1'b0;
        end else begin
            r_ready  <= 1'b1;
            r_sreq_m <= {rcv1_req, rcv0_req};
            r_sreq   <= r_sreq_m;
            r_sack_m <= snd0_ack;
            r_sack   <= r_sack_m;
        end
    end

    always_ff @(posedge i_clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                r_rx_st[i] <= RxIdle;
            end
            r_full    <= '0;
            r_buf     <= '0;
            r_tx_st   <= TxIdle;
            r_sel     <= 1'b0;
            r_ptr     <= 1'b0;
            r_snd_dat <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                r_rx_st[i] <= w_rx_st_nx[i];
            end
            r_full    <= w_full_nx;
            r_buf     <= w_buf_nx;
            r_tx_st   <= w_tx_st_nx;
            r_sel     <= w_sel_nx;
            r_ptr     <= w_ptr_nx;
            r_snd_dat <= w_snd_dat_nx;
        end
    end

    // Set (receive) requires an empty buffer and clear (send) a full one, so they never collide.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_rx_st_nx[i] = r_rx_st[i];
        end
        w_full_nx    = r_full;
        w_buf_nx     = r_buf;
        w_tx_st_nx   = r_tx_st;
        w_sel_nx     = r_sel;
        w_ptr_nx     = r_ptr;
        w_snd_dat_nx = r_snd_dat;

        for (int i = 0; i < 2; i++) begin
            case (r_rx_st[i])
                RxIdle: begin
                    if (r_sreq[i] && !r_full[i]) begin
                        w_buf_nx[i]   = w_rcv_dat[i];
                        w_full_nx[i]  = 1'b1;
                        w_rx_st_nx[i] = RxWaitLo;
                    end
                end
                RxWaitLo: begin
                    if (!r_sreq[i]) begin
                        w_rx_st_nx[i] = RxIdle;
                    end
                end
                default: w_rx_st_nx[i] = RxIdle;
            endcase
        end

        case (r_tx_st)
            TxIdle: begin
                if (|r_full) begin
                    w_sel_nx     = (r_full[0] && r_full[1]) ? r_ptr : r_full[1];
                    w_snd_dat_nx = r_buf[w_sel_nx];
                    w_tx_st_nx   = TxWaitHi;
                end
            end
            TxWaitHi: begin
                if (r_sack) begin
                    w_full_nx[r_sel] = 1'b0;
                    w_ptr_nx         = ~r_sel;
                    w_tx_st_nx       = TxWaitLo;
                end
            end
            TxWaitLo: begin
                if (!r_sack) begin
                    w_tx_st_nx = TxIdle;
                end
            end
            default: w_tx_st_nx = TxIdle;
        endcase
    end

    assign ready    = r_ready;
    assign rcv0_ack = (r_rx_st[0] == RxWaitLo);
    assign rcv1_ack = (r_rx_st[1] == RxWaitLo);
    assign snd0_req = (r_tx_st == TxWaitHi);
    assign snd0_dat = r_snd_dat;

endmodule

// File: tb/tb_nd_2to1.sv
// Self-checking bench for nd_2to1: scoreboard queues per input, vector table, corner sequences.
`timescale 1ns/1ps

module tb_nd_2to1;
    localparam int ASZ   = 8;
    localparam int DSZ   = 8;
    localparam int RSZ   = 4;
    localparam int MSZ   = ASZ + DSZ + RSZ;
    localparam int LIMIT = 5000;

    typedef logic [MSZ-1:0] msg_t;
    typedef struct {
        int   ch;
        msg_t dat;
        msg_t exp;
    } vec_t;

    logic i_clk    = 1'b0;
    logic reset    = 1'b1;
    logic ready;
    logic rcv0_req = 1'b0;
    msg_t rcv0_dat = '0;
    logic rcv0_ack;
    logic rcv1_req = 1'b0;
    msg_t rcv1_dat = '0;
    logic rcv1_ack;
    logic snd0_req;
    msg_t snd0_dat;
    logic snd0_ack = 1'b0;

    int   total = 0;
    int   bad   = 0;
    msg_t q0[$];
    msg_t q1[$];
    msg_t log_q[$];
    int   src_log[$];
    int   n_done  = 0;
    bit   hold    = 1'b0;
    int   ack_dly = 3;

    nd_2to1 #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) dut (
        .i_clk    (i_clk),
        .reset    (reset),
        .ready    (ready),
        .rcv0_req (rcv0_req),
        .rcv0_dat (rcv0_dat),
        .rcv0_ack (rcv0_ack),
        .rcv1_req (rcv1_req),
        .rcv1_dat (rcv1_dat),
        .rcv1_ack (rcv1_ack),
        .snd0_req (snd0_req),
        .snd0_dat (snd0_dat),
        .snd0_ack (snd0_ack)
    );

    initial forever #5 i_clk = ~i_clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic get_ack(input int ch);
        return (ch == 0) ? rcv0_ack : rcv1_ack;
    endfunction

    function automatic int count_log(input msg_t w);
        int c = 0;
        foreach (log_q[k]) if (log_q[k] == w) c++;
        return c;
    endfunction

    // Output peer: acks after ack_dly cycles unless held off.
    initial begin : responder
        int cnt;
        cnt = 0;
        forever begin
            @(negedge i_clk);
            if (snd0_req && !snd0_ack) begin
                if (!hold) begin
                    if (cnt >= ack_dly) begin
                        snd0_ack = 1'b1;
                        cnt = 0;
                    end else begin
                        cnt++;
                    end
                end
            end else if (!snd0_req && snd0_ack) begin
                snd0_ack = 1'b0;
            end
        end
    end

    // Output monitor: matches each new request against the head of either input queue.
    initial begin : monitor
        logic prev_req;
        msg_t held;
        msg_t h0;
        msg_t h1;
        prev_req = 1'b0;
        held = '0;
        forever begin
            @(negedge i_clk);
            if (snd0_req && !prev_req) begin
                held = snd0_dat;
                log_q.push_back(snd0_dat);
                total++;
                if (q0.size() > 0 && snd0_dat == q0[0]) begin
                    void'(q0.pop_front());
                    src_log.push_back(0);
                end else if (q1.size() > 0 && snd0_dat == q1[0]) begin
                    void'(q1.pop_front());
                    src_log.push_back(1);
                end else begin
                    bad++;
                    src_log.push_back(2);
                    h0 = (q0.size() > 0) ? q0[0] : '0;
                    h1 = (q1.size() > 0) ? q1[0] : '0;
                    $display("FAIL sb_match: got %0h expected head0 %0h (n=%0d) or head1 %0h (n=%0d)",
                             snd0_dat, h0, q0.size(), h1, q1.size());
                end
            end else if (snd0_req && prev_req) begin
                chk("dat_stable", snd0_dat, held);
            end
            if (!snd0_req && prev_req) n_done++;
            prev_req = snd0_req;
        end
    end

    task automatic set_req(input int ch, input logic v);
        if (ch == 0) rcv0_req = v;
        else rcv1_req = v;
    endtask

    task automatic send(input int ch, input msg_t d, input int div);
        int n;
        repeat (div) @(negedge i_clk);
        if (ch == 0) begin
            rcv0_dat = d;
            q0.push_back(d);
        end else begin
            rcv1_dat = d;
            q1.push_back(d);
        end
        set_req(ch, 1'b1);
        n = 0;
        while (!get_ack(ch) && n < LIMIT) begin
            @(negedge i_clk);
            n++;
        end
        chk($sformatf("ack_rise_ch%0d", ch), get_ack(ch), 1);
        repeat (div) @(negedge i_clk);
        set_req(ch, 1'b0);
        n = 0;
        while (get_ack(ch) && n < LIMIT) begin
            @(negedge i_clk);
            n++;
        end
        chk($sformatf("ack_fall_ch%0d", ch), get_ack(ch), 0);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || snd0_req || snd0_ack || rcv0_ack || rcv1_ack)
               && n < LIMIT) begin
            @(negedge i_clk);
            n++;
        end
        chk(name, (n < LIMIT), 1);
        repeat (4) @(negedge i_clk);
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        reset = 1'b1;
        repeat (4) @(posedge i_clk);
        #1;
        chk("rst_ready", ready, 0);
        chk("rst_ack0", rcv0_ack, 0);
        chk("rst_ack1", rcv1_ack, 0);
        chk("rst_snd_req", snd0_req, 0);
        chk("rst_snd_dat", snd0_dat, 0);
        @(negedge i_clk);
        reset = 1'b0;
        @(posedge i_clk);
        #1;
        chk("ready_up", ready, 1);
    endtask

    initial begin : main
        vec_t vecs[6];
        msg_t w;
        int   base;
        int   nd;
        int   n;
        int   d0;
        int   d1;

        vecs[0] = '{0, {8'd23, 8'd5, 4'd0}, {8'd23, 8'd5, 4'd0}};
        vecs[1] = '{1, {MSZ{1'b1}}, {MSZ{1'b1}}};
        vecs[2] = '{0, {MSZ{1'b0}}, {MSZ{1'b0}}};
        vecs[3] = '{1, {8'd40, 8'hC3, 4'hA}, {8'd40, 8'hC3, 4'hA}};
        vecs[4] = '{0, {MSZ{1'b1}}, {MSZ{1'b1}}};
        vecs[5] = '{1, {8'h81, 8'h7E, 4'h5}, {8'h81, 8'h7E, 4'h5}};

        do_reset();

        // Single message with cycle-exact latency.
        ack_dly = 3;
        w = {8'd23, 8'd5, 4'd0};
        @(negedge i_clk);
        rcv0_dat = w;
        q0.push_back(w);
        rcv0_req = 1'b1;
        @(posedge i_clk); #1;
        chk("lat_k_ack", rcv0_ack, 0);
        @(posedge i_clk); #1;
        chk("lat_k1_ack", rcv0_ack, 0);
        @(posedge i_clk); #1;
        chk("lat_k2_ack", rcv0_ack, 1);
        chk("lat_k2_req", snd0_req, 0);
        @(posedge i_clk); #1;
        chk("lat_k3_req", snd0_req, 1);
        chk("lat_k3_dat", snd0_dat, w);
        @(negedge i_clk);
        rcv0_req = 1'b0;
        wait_idle("lat_idle");
        chk("lat_ready", ready, 1);

        foreach (vecs[i]) begin
            send(vecs[i].ch, vecs[i].dat, 1);
            wait_idle("vec_idle");
            chk($sformatf("vec%0d_dat", i), log_q[log_q.size()-1], vecs[i].exp);
            chk($sformatf("vec%0d_src", i), src_log[src_log.size()-1], vecs[i].ch);
        end

        // Simultaneous arrival from a fresh pointer: 30 then 40, twice.
        do_reset();
        ack_dly = 2;
        for (int r = 0; r < 2; r++) begin
            base = log_q.size();
            fork
                send(0, {8'd30, 8'd1, 4'd0}, 1);
                send(1, {8'd40, 8'd1, 4'd0}, 1);
            join
            wait_idle("sim_idle");
            chk($sformatf("sim%0d_first", r), log_q[base], {8'd30, 8'd1, 4'd0});
            chk($sformatf("sim%0d_second", r), log_q[base+1], {8'd40, 8'd1, 4'd0});
        end

        // Backpressure: second message on rcv1 is not acked until the first completes.
        hold = 1'b1;
        send(1, {8'd50, 8'd1, 4'd1}, 1);
        repeat (50) @(negedge i_clk);
        fork
            send(1, {8'd50, 8'd2, 4'd1}, 1);
            begin
                repeat (20) @(negedge i_clk);
                chk("bp_ack_low", rcv1_ack, 0);
                chk("bp_req_held", snd0_req, 1);
                nd = n_done;
                hold = 1'b0;
                n = 0;
                while (!rcv1_ack && n < LIMIT) begin
                    @(negedge i_clk);
                    n++;
                end
                chk("bp_ack_after_done", n_done, nd + 1);
            end
        join
        wait_idle("bp_idle");

        // A request held high for 100 cycles is captured once.
        w = {8'hA5, 8'h3C, 4'h9};
        @(negedge i_clk);
        rcv0_dat = w;
        q0.push_back(w);
        rcv0_req = 1'b1;
        repeat (100) @(negedge i_clk);
        chk("hold_ack_high", rcv0_ack, 1);
        rcv0_req = 1'b0;
        wait_idle("hold_idle");
        chk("hold_once", count_log(w), 1);

        // Streams: slow output keeps both buffers full in the first configuration.
        for (int cfg = 0; cfg < 2; cfg++) begin
            d0 = (cfg == 0) ? 2 : 8;
            d1 = (cfg == 0) ? 8 : 32;
            ack_dly = (cfg == 0) ? 32 : 2;
            base = src_log.size();
            fork
                for (int i = 0; i < 16; i++) send(0, {8'h10, 8'(i), 4'h3}, d0);
                for (int i = 0; i < 16; i++) send(1, {8'h20, 8'(i), 4'h3}, d1);
            join
            wait_idle("stream_idle");
            chk($sformatf("stream%0d_cnt", cfg), src_log.size() - base, 32);
            if (cfg == 0) begin
                for (int k = base + 1; k < src_log.size(); k++) begin
                    chk($sformatf("alt_%0d", k - base), (src_log[k] != src_log[k-1]), 1);
                end
            end
        end

        // Reset while a send is pending and buf1 is full.
        ack_dly = 2;
        hold = 1'b1;
        send(0, {8'd60, 8'd1, 4'd2}, 1);
        send(1, {8'd61, 8'd1, 4'd2}, 1);
        repeat (5) @(negedge i_clk);
        chk("rm_req_pre", snd0_req, 1);
        @(negedge i_clk);
        reset = 1'b1;
        @(posedge i_clk); #1;
        chk("rm_snd_req", snd0_req, 0);
        chk("rm_ack0", rcv0_ack, 0);
        chk("rm_ack1", rcv1_ack, 0);
        chk("rm_ready", ready, 0);
        @(negedge i_clk);
        reset = 1'b0;
        q0.delete();
        q1.delete();
        hold = 1'b0;
        base = log_q.size();
        repeat (30) @(negedge i_clk);
        chk("rm_discard", log_q.size(), base);
        chk("rm_ready_up", ready, 1);
        w = {8'd62, 8'd7, 4'd2};
        send(1, w, 1);
        wait_idle("rm_idle");
        chk("rm_once", count_log(w), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
